enigma_step_ctrl: RTL and testbench

// Sequences one keypress through the three-rotor datapath: decides which rotors step (right always,

---
 rtl/enigma_step_ctrl_if.sv | 41 ++++
 rtl/enigma_step_ctrl.sv | 154 +++++++++++++++
 tb/tb_enigma_step_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/enigma_step_ctrl_if.sv
// Handshake and datapath bundle between the keypress sequencer and its surroundings.
// The slave side is the controller; the master side is the keyboard logic plus the rotor chain.
interface enigma_step_ctrl_if;
    logic [25:0] key_in;
    logic        key_valid;
    logic        key_ready;
    logic        key_err;
    logic        set_req;
    logic [4:0]  set_pos_l;
    logic [4:0]  set_pos_m;
    logic [4:0]  set_pos_r;
    logic        set_err;
    logic        notch_l;
    logic        notch_m;
    logic        notch_r;
    logic        rotate_l;
    logic        rotate_m;
    logic        rotate_r;
    logic [25:0] dp_in;
    logic [25:0] dp_out;
    logic [25:0] cipher_out;
    logic        cipher_valid;
    logic [4:0]  pos_l;
    logic [4:0]  pos_m;
    logic [4:0]  pos_r;
    logic        busy;

    modport slave (
        input  key_in, key_valid, set_req, set_pos_l, set_pos_m, set_pos_r,
               notch_l, notch_m, notch_r, dp_out,
        output key_ready, key_err, set_err, rotate_l, rotate_m, rotate_r,
               dp_in, cipher_out, cipher_valid, pos_l, pos_m, pos_r, busy
    );

    modport master (
        output key_in, key_valid, set_req, set_pos_l, set_pos_m, set_pos_r,
               notch_l, notch_m, notch_r, dp_out,
        input  key_ready, key_err, set_err, rotate_l, rotate_m, rotate_r,
               dp_in, cipher_out, cipher_valid, pos_l, pos_m, pos_r, busy
    );
endinterface

// File: rtl/enigma_step_ctrl.sv
// Keypress sequencer for a three-rotor cipher: steps rotors (with double-step), lets the
// rotor/reflector path settle, captures the ciphertext letter, and realigns rotors on request.
module enigma_step_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic               clock,
    input  logic               resetn,
    enigma_step_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, STEP_HI, STEP_LO, SETTLE, SET_CHK, SET_HI, SET_LO
    } state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e      state_q;
    logic [25:0] key_q;
    logic [25:0] dp_in_q;
    logic [25:0] cipher_q;
    logic        cipher_valid_q;
    logic        key_err_q;
    logic        set_err_q;
    logic        rot_l_q, rot_m_q, rot_r_q;
    logic [4:0]  pos_l_q, pos_m_q, pos_r_q;
    logic [4:0]  tgt_l_q, tgt_m_q, tgt_r_q;
    logic [3:0]  settle_cnt_q;

    logic key_onehot_d;
    logic set_bad_d;
    logic at_target_d;

    function automatic logic [4:0] inc26(input logic [4:0] p);
        return (p == 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    assign key_onehot_d = (bus.key_in != 26'd0) &&
                          ((bus.key_in & (bus.key_in - 26'd1)) == 26'd0);
    assign set_bad_d    = (bus.set_pos_l > 5'd25) || (bus.set_pos_m > 5'd25) ||
                          (bus.set_pos_r > 5'd25);
    assign at_target_d  = (pos_l_q == tgt_l_q) && (pos_m_q == tgt_m_q) &&
                          (pos_r_q == tgt_r_q);

    // Gated by resetn so a key offered during reset is never seen as accepted.
    assign bus.key_ready    = resetn && (state_q == IDLE) && !bus.set_req;
    assign bus.key_err      = key_err_q;
    assign bus.set_err      = set_err_q;
    assign bus.rotate_l     = rot_l_q;
    assign bus.rotate_m     = rot_m_q;
    assign bus.rotate_r     = rot_r_q;
    assign bus.dp_in        = dp_in_q;
    assign bus.cipher_out   = cipher_q;
    assign bus.cipher_valid = cipher_valid_q;
    assign bus.pos_l        = pos_l_q;
    assign bus.pos_m        = pos_m_q;
    assign bus.pos_r        = pos_r_q;
    assign bus.busy         = (state_q != IDLE);

    // NOTE: every register here updates with <= so all of them see pre-edge values of each other.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            key_q          <= '0;
            dp_in_q        <= '0;
            cipher_q       <= '0;
            cipher_valid_q <= 1'b0;
            key_err_q      <= 1'b0;
            set_err_q      <= 1'b0;
            rot_l_q        <= 1'b0;
            rot_m_q        <= 1'b0;
            rot_r_q        <= 1'b0;
            pos_l_q        <= '0;
            pos_m_q        <= '0;
            pos_r_q        <= '0;
            tgt_l_q        <= '0;
            tgt_m_q        <= '0;
            tgt_r_q        <= '0;
            settle_cnt_q   <= '0;
        end else begin
            cipher_valid_q <= 1'b0;
            key_err_q      <= 1'b0;
            set_err_q      <= 1'b0;
            rot_l_q        <= 1'b0;
            rot_m_q        <= 1'b0;
            rot_r_q        <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.set_req) begin
                        if (set_bad_d) begin
                            set_err_q <= 1'b1;
                        end else begin
                            tgt_l_q <= bus.set_pos_l;
                            tgt_m_q <= bus.set_pos_m;
                            tgt_r_q <= bus.set_pos_r;
                            state_q <= SET_CHK;
                        end
                    end else if (bus.key_valid) begin
                        if (!key_onehot_d) begin
                            key_err_q <= 1'b1;
                        end else begin
                            // Middle notch steps middle and left together: the double step.
                            key_q   <= bus.key_in;
                            rot_r_q <= 1'b1;
                            rot_m_q <= bus.notch_r | bus.notch_m;
                            rot_l_q <= bus.notch_m;
                            state_q <= STEP_HI;
                        end
                    end
                end

                STEP_HI, SET_HI: begin
                    if (rot_l_q) pos_l_q <= inc26(pos_l_q);
                    if (rot_m_q) pos_m_q <= inc26(pos_m_q);
                    if (rot_r_q) pos_r_q <= inc26(pos_r_q);
                    state_q <= (state_q == STEP_HI) ? STEP_LO : SET_LO;
                end

                STEP_LO: begin
                    dp_in_q      <= key_q;
                    settle_cnt_q <= '0;
                    state_q      <= SETTLE;
                end

                SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        cipher_q       <= bus.dp_out;
                        cipher_valid_q <= 1'b1;
                        dp_in_q        <= '0;
                        state_q        <= IDLE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 4'd1;
                    end
                end

                SET_CHK: begin
                    if (at_target_d) begin
                        state_q <= IDLE;
                    end else begin
                        rot_l_q <= (pos_l_q != tgt_l_q);
                        rot_m_q <= (pos_m_q != tgt_m_q);
                        rot_r_q <= (pos_r_q != tgt_r_q);
                        state_q <= SET_HI;
                    end
                end

                SET_LO:  state_q <= SET_CHK;

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Bench for enigma_step_ctrl: a transaction-level model expands each keypress or realignment
// into its expected per-cycle outputs, and one process compares the DUT against them every cycle.
module tb_enigma_step_ctrl;

    localparam int S = 2;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    enigma_step_ctrl_if bus ();

    enigma_step_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic        rl, rm, rr;
        logic [25:0] dp;
        logic        cv;
        logic [25:0] co;
        logic        busy, kerr, serr;
        int          pl, pm, pr;
    } exp_t;

    exp_t        exp_q[$];
    int          m_pl, m_pm, m_pr;
    logic [25:0] m_cipher;
    int          checks = 0;
    int          errors = 0;
    int          cnt_rl = 0, cnt_rm = 0, cnt_rr = 0, cnt_busy = 0, cnt_cv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t idle_rec();
        exp_t r;
        r.rl = 0; r.rm = 0; r.rr = 0;
        r.dp = '0; r.cv = 0; r.co = m_cipher;
        r.busy = 0; r.kerr = 0; r.serr = 0;
        r.pl = m_pl; r.pm = m_pm; r.pr = m_pr;
        return r;
    endfunction

    // Single compare process: one expected record per cycle, idle when no transaction is pending.
    always @(negedge clock) begin
        exp_t e;
        if (!resetn) begin
            check("rst_key_ready", 32'(bus.key_ready), 32'd0);
            check("rst_rotate", 32'({bus.rotate_l, bus.rotate_m, bus.rotate_r}), 32'd0);
            check("rst_flags", 32'({bus.key_err, bus.set_err, bus.cipher_valid, bus.busy}), 32'd0);
            check("rst_dp_in", 32'(bus.dp_in), 32'd0);
            check("rst_cipher", 32'(bus.cipher_out), 32'd0);
            check("rst_pos", 32'({bus.pos_l, bus.pos_m, bus.pos_r}), 32'd0);
        end else begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_rec();
            check("rotate", 32'({bus.rotate_l, bus.rotate_m, bus.rotate_r}), 32'({e.rl, e.rm, e.rr}));
            check("dp_in", 32'(bus.dp_in), 32'(e.dp));
            check("cipher_valid", 32'(bus.cipher_valid), 32'(e.cv));
            check("cipher_out", 32'(bus.cipher_out), 32'(e.co));
            check("busy", 32'(bus.busy), 32'(e.busy));
            check("key_err", 32'(bus.key_err), 32'(e.kerr));
            check("set_err", 32'(bus.set_err), 32'(e.serr));
            check("key_ready", 32'(bus.key_ready), 32'(!e.busy && !bus.set_req));
            check("pos_l", 32'(bus.pos_l), 32'(e.pl));
            check("pos_m", 32'(bus.pos_m), 32'(e.pm));
            check("pos_r", 32'(bus.pos_r), 32'(e.pr));
            if (bus.rotate_l) cnt_rl++;
            if (bus.rotate_m) cnt_rm++;
            if (bus.rotate_r) cnt_rr++;
            if (bus.busy) cnt_busy++;
            if (bus.cipher_valid) cnt_cv++;
        end
    end

    task automatic wait_done();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            @(posedge clock);
            guard++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    // One keypress; abort_at > 0 pulls resetn low that many edges after acceptance.
    task automatic do_key(input logic [25:0] k, input logic nr, input logic nm,
                          input logic [25:0] dout, input bit poke_set, input int abort_at);
        exp_t e;
        int   sl, sm;
        bus.key_in    = k;
        bus.notch_r   = nr;
        bus.notch_m   = nm;
        bus.dp_out    = dout;
        bus.key_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.key_valid = 1'b0;
        if ($countones(k) != 1) begin
            e = idle_rec(); e.kerr = 1; exp_q.push_back(e);
        end else begin
            sl = nm ? 1 : 0;
            sm = (nr || nm) ? 1 : 0;
            e = idle_rec(); e.busy = 1; e.rr = 1; e.rm = sm[0]; e.rl = sl[0];
            exp_q.push_back(e);
            m_pl = (m_pl + sl) % 26;
            m_pm = (m_pm + sm) % 26;
            m_pr = (m_pr + 1) % 26;
            e = idle_rec(); e.busy = 1; exp_q.push_back(e);
            for (int i = 0; i < S; i++) begin
                e = idle_rec(); e.busy = 1; e.dp = k; exp_q.push_back(e);
            end
            m_cipher = dout;
            e = idle_rec(); e.cv = 1; exp_q.push_back(e);
        end
        if (poke_set) begin
            @(posedge clock); #1;
            bus.set_pos_l = 5'd7; bus.set_pos_m = 5'd7; bus.set_pos_r = 5'd7;
            bus.set_req = 1'b1;
            repeat (2) @(posedge clock);
            #1 bus.set_req = 1'b0;
        end
        if (abort_at > 0) begin
            repeat (abort_at) @(posedge clock);
            #1 resetn = 1'b0;
            exp_q.delete();
            m_pl = 0; m_pm = 0; m_pr = 0; m_cipher = '0;
            repeat (2) @(posedge clock);
            #1 resetn = 1'b1;
        end
        wait_done();
    endtask

    task automatic do_set(input int tl, input int tm, input int tr);
        exp_t e;
        int   dl, dm, dr, n;
        bus.set_pos_l = 5'(tl);
        bus.set_pos_m = 5'(tm);
        bus.set_pos_r = 5'(tr);
        bus.set_req   = 1'b1;
        @(posedge clock);
        #1;
        bus.set_req = 1'b0;
        if (tl > 25 || tm > 25 || tr > 25) begin
            e = idle_rec(); e.serr = 1; exp_q.push_back(e);
        end else begin
            dl = (tl - m_pl + 26) % 26;
            dm = (tm - m_pm + 26) % 26;
            dr = (tr - m_pr + 26) % 26;
            n  = dl;
            if (dm > n) n = dm;
            if (dr > n) n = dr;
            e = idle_rec(); e.busy = 1; exp_q.push_back(e);
            for (int it = 0; it < n; it++) begin
                e = idle_rec(); e.busy = 1;
                e.rl = (it < dl); e.rm = (it < dm); e.rr = (it < dr);
                exp_q.push_back(e);
                if (it < dl) m_pl = (m_pl + 1) % 26;
                if (it < dm) m_pm = (m_pm + 1) % 26;
                if (it < dr) m_pr = (m_pr + 1) % 26;
                e = idle_rec(); e.busy = 1; exp_q.push_back(e);
                e = idle_rec(); e.busy = 1; exp_q.push_back(e);
            end
        end
        wait_done();
    endtask

    initial begin
        int b_rl, b_rm, b_rr, b_busy, b_cv;
        m_pl = 0; m_pm = 0; m_pr = 0; m_cipher = '0;
        bus.key_in = 26'd1; bus.key_valid = 1'b1; bus.set_req = 1'b0;
        bus.set_pos_l = '0; bus.set_pos_m = '0; bus.set_pos_r = '0;
        bus.notch_l = 1'b0; bus.notch_m = 1'b0; bus.notch_r = 1'b0;
        bus.dp_out = '0;

        // T1: reset held with a key offered
        repeat (3) @(posedge clock);
        #1 bus.key_valid = 1'b0;
        @(posedge clock);
        #1 resetn = 1'b1;
        #2 check("t1_ready_after_release", 32'(bus.key_ready), 32'd1);
        @(posedge clock); #1;

        // T2: no notches, key A, rotor chain returns F
        b_rl = cnt_rl; b_rm = cnt_rm; b_rr = cnt_rr;
        do_key(26'h1, 1'b0, 1'b0, 26'h20, 1'b0, 0);
        check("t2_steps", 32'({8'(cnt_rl - b_rl), 8'(cnt_rm - b_rm), 8'(cnt_rr - b_rr)}), 32'h000001);
        check("t2_pos", 32'({bus.pos_l, bus.pos_m, bus.pos_r}), 32'({5'd0, 5'd0, 5'd1}));
        check("t2_cipher", 32'(bus.cipher_out), 32'h20);

        // T3: right notch steps middle; middle notch double-steps (set_req while busy ignored)
        b_rl = cnt_rl; b_rm = cnt_rm; b_rr = cnt_rr;
        do_key(26'h2, 1'b1, 1'b0, 26'h80, 1'b0, 0);
        check("t3a_steps", 32'({8'(cnt_rl - b_rl), 8'(cnt_rm - b_rm), 8'(cnt_rr - b_rr)}), 32'h000101);
        b_rl = cnt_rl; b_rm = cnt_rm; b_rr = cnt_rr;
        do_key(26'h2000000, 1'b0, 1'b1, 26'h1, 1'b1, 0);
        check("t3b_steps", 32'({8'(cnt_rl - b_rl), 8'(cnt_rm - b_rm), 8'(cnt_rr - b_rr)}), 32'h010101);
        check("t3_pos", 32'({bus.pos_l, bus.pos_m, bus.pos_r}), 32'({5'd1, 5'd2, 5'd3}));

        // T5: malformed key and out-of-range target
        b_rr = cnt_rr; b_cv = cnt_cv;
        do_key(26'h3, 1'b0, 1'b0, 26'h4, 1'b0, 0);
        do_key(26'h0, 1'b0, 1'b0, 26'h4, 1'b0, 0);
        do_set(2, 2, 26);
        check("t5_no_activity", 32'({8'(cnt_rr - b_rr), 8'(cnt_cv - b_cv)}), 32'd0);
        check("t5_pos_kept", 32'({bus.pos_l, bus.pos_m, bus.pos_r}), 32'({5'd1, 5'd2, 5'd3}));

        // T6: reset during SETTLE
        b_cv = cnt_cv;
        do_key(26'h10, 1'b0, 1'b0, 26'h100, 1'b0, 3);
        check("t6_no_cipher_valid", 32'(cnt_cv - b_cv), 32'd0);
        check("t6_pos_cleared", 32'({bus.pos_l, bus.pos_m, bus.pos_r}), 32'd0);

        // T4: realign 3/0/25, then 3/0/0 so the right rotor wraps
        b_rl = cnt_rl; b_rm = cnt_rm; b_rr = cnt_rr; b_busy = cnt_busy;
        do_set(3, 0, 25);
        check("t4_steps", 32'({8'(cnt_rl - b_rl), 8'(cnt_rm - b_rm), 8'(cnt_rr - b_rr)}), 32'h030019);
        check("t4_busy_cycles", 32'(cnt_busy - b_busy), 32'd76);
        check("t4_pos", 32'({bus.pos_l, bus.pos_m, bus.pos_r}), 32'({5'd3, 5'd0, 5'd25}));
        b_rl = cnt_rl; b_rm = cnt_rm; b_rr = cnt_rr;
        do_set(3, 0, 0);
        check("t4_wrap_steps", 32'({8'(cnt_rl - b_rl), 8'(cnt_rm - b_rm), 8'(cnt_rr - b_rr)}), 32'h000001);
        check("t4_wrap_pos", 32'({bus.pos_l, bus.pos_m, bus.pos_r}), 32'({5'd3, 5'd0, 5'd0}));

        // Key after realignment with pos already at targets
        do_set(3, 0, 0);
        do_key(26'h400, 1'b1, 1'b1, 26'h3, 1'b0, 0);
        check("final_pos", 32'({bus.pos_l, bus.pos_m, bus.pos_r}), 32'({5'd4, 5'd1, 5'd1}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
